fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage; sits directly upstream of the decode stage and produces the IF_ID pipeline register every cycle.
- Maintains the PC and issues in-order requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a small FIFO.
- Handles jump redirects from execute by flushing and discarding stale in-flight responses.
- Presents a bubble (do_not_execute=1) whenever no instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
DEPTH, 2, FIFO entries; also caps the sum of outstanding requests and buffered instructions (power of 2, >=2).
NOP_INST, 32'h0000_0013, instruction word driven in bubbles (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address (current PC)
imem_rsp_valid  input  1  response valid; responses return in request order
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  taken jump from execute, single-cycle pulse
redirect_pc  input  32  jump target
if_id_r  output  IF_ID  registered {pc[31:0], fetched_inst[31:0], do_not_execute}

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- Reset values:
  - pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = RUN.
  - if_id_r = {pc:0, fetched_inst:NOP_INST, do_not_execute:1}.
- Counters: outstanding and discard, each 0..DEPTH.
- Request issue:
  - imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + fifo_count < DEPTH).
  - imem_req_addr = pc.
  - Accepted when imem_req_valid && imem_req_ready: pc <= pc+4 (mod 2^32), and outstanding increments.
- Response, no discard pending: push {issue_pc, imem_rsp_data} into FIFO and decrement outstanding. issue_pc comes from an internal PC tag queue.
  - The credit rule guarantees the FIFO never overflows.
  - A response while outstanding==0 is illegal (assertion).
- Output, every clock:
  - FIFO non-empty and no redirect: pop head; if_id_r <= {head.pc, head.inst, 0}.
  - Otherwise: bubble, if_id_r <= {0, NOP_INST, 1}.
  - Latency: an instruction whose response arrives in cycle N (FIFO empty) appears on if_id_r after edge N+1. Push and pop in the same cycle are allowed.
- Redirect (redirect_valid=1 in cycle N):
  - FIFO flushed; edge N produces a bubble; pc <= {redirect_pc[31:2], 2'b00}; no request issued in cycle N.
  - discard <= outstanding after counting cycle N's response. A response arriving in cycle N is dropped.
  - If the new discard > 0, state <= FLUSH, else stay RUN.
- FLUSH state:
  - No requests issued.
  - Each response decrements discard and outstanding, and is not pushed.
  - When discard reaches 0, return to RUN; the next cycle may issue from the new pc.
- Redirect during FLUSH: pc is updated and discard is recomputed from the current outstanding. State stays FLUSH unless outstanding is 0.
- Redirect has priority over pop, push and issue in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Full: at outstanding + fifo_count == DEPTH, imem_req_valid=0 until a pop occurs. Decode consumes every cycle, so the stall is at most transient.

Test Plan:
- Reset release, 1-cycle memory, always ready, responses returning addr/4+0x100 -> if_id_r shows bubbles, then pc=0,4,8,... with inst=0x100,0x101,0x102 and do_not_execute=0 back-to-back.
- Memory latency 3, ready always -> at most 2 outstanding; imem_req_valid drops when credits are exhausted; no lost or duplicated pc; bubbles fill the gaps.
- Redirect to 0x0000_0202 with 2 requests in flight -> pc becomes 0x200; both stale responses dropped; first valid output is pc=0x200; no requests issued while in FLUSH.
- Redirect in the same cycle as a response and a non-empty FIFO -> response and FIFO dropped; bubble on the next edge; fetch resumes at the target.
- Second redirect (to 0x300) during FLUSH after first redirect (to 0x100) -> only pc=0x300 stream emerges; nothing from 0x100.
- imem_req_ready held low 5 cycles, then pc wrap from 0xFFFF_FFFC -> pc is held while stalled; next fetch address after 0xFFFF_FFFC is 0x0000_0000; asynchronous reset asserted mid-burst clears if_id_r to a bubble immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited in-order imem requests, response FIFO,
// redirect flush with stale-response discard, and the registered IF_ID output.
package fetch_unit_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] fetched_inst;
    logic        do_not_execute;
  } if_id_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output if_id_t      if_id_r
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] f_cnt_q, f_cnt_d;
  logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  logic [PW-1:0] t_rd_q, t_rd_d, t_wr_q, t_wr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_d   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];
  logic [31:0]   tag_q       [DEPTH];
  logic [31:0]   tag_d       [DEPTH];
  if_id_t        if_id_q, if_id_d;

  logic          credit, req_fire, push, pop;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Outstanding requests plus buffered words never exceed the FIFO size.
  assign credit         = ({1'b0, out_q} + {1'b0, f_cnt_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = (state_q == RUN) && !redirect_valid && credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign pop            = (f_cnt_q != '0) && !redirect_valid;
  assign if_id_r        = if_id_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    disc_d      = disc_q;
    f_cnt_d     = f_cnt_q;
    f_rd_d      = f_rd_q;
    f_wr_d      = f_wr_q;
    t_rd_d      = t_rd_q;
    t_wr_d      = t_wr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    tag_d       = tag_q;
    if_id_d     = '{pc: 32'h0, fetched_inst: NOP_INST, do_not_execute: 1'b1};

    if (req_fire) begin
      pc_d          = pc_q + 32'd4;
      tag_d[t_wr_q] = pc_q;
      t_wr_d        = t_wr_q + PW'(1);
    end
    // Every response, kept or discarded, retires its PC tag.
    if (imem_rsp_valid) t_rd_d = t_rd_q + PW'(1);

    unique case ({req_fire, imem_rsp_valid})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: ;
    endcase

    if (pop) begin
      if_id_d = '{pc: fifo_pc_q[f_rd_q], fetched_inst: fifo_inst_q[f_rd_q], do_not_execute: 1'b0};
      f_rd_d  = f_rd_q + PW'(1);
    end
    if (push) begin
      fifo_pc_d[f_wr_q]   = tag_q[t_rd_q];
      fifo_inst_d[f_wr_q] = imem_rsp_data;
      f_wr_d              = f_wr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   f_cnt_d = f_cnt_q + CW'(1);
      2'b01:   f_cnt_d = f_cnt_q - CW'(1);
      default: ;
    endcase

    if (state_q == FLUSH && imem_rsp_valid) begin
      disc_d = disc_q - CW'(1);
      if (disc_q == CW'(1)) state_d = RUN;
    end

    // Redirect overrides everything: drop buffered words, discard all still in flight.
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      f_cnt_d = '0;
      f_rd_d  = f_wr_q;
      f_wr_d  = f_wr_q;
      disc_d  = out_d;
      state_d = (out_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      f_cnt_q <= '0;
      f_rd_q  <= '0;
      f_wr_q  <= '0;
      t_rd_q  <= '0;
      t_wr_q  <= '0;
      if_id_q <= '{pc: 32'h0, fetched_inst: NOP_INST, do_not_execute: 1'b1};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      f_cnt_q     <= f_cnt_d;
      f_rd_q      <= f_rd_d;
      f_wr_q      <= f_wr_d;
      t_rd_q      <= t_rd_d;
      t_wr_q      <= t_wr_d;
      if_id_q     <= if_id_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      tag_q       <= tag_d;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> (out_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory, epoch-tagged requests,
// and a scoreboard of expected IF_ID words with the exact edge each must appear on.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [64:0] BUBBLE   = {32'h0, NOP_INST, 1'b1};

  logic        clk = 0;
  logic        reset_n = 1;
  logic        imem_req_valid;
  logic        imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  if_id_t      if_id_r;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_r(if_id_r)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
  typedef struct { logic [64:0] v; int e; } sb_t;

  mreq_t       pend[$];   // accepted by memory, response not yet returned
  sb_t         sbq[$];    // expected non-bubble outputs, in order
  int          edge_cnt = 0, epoch = 0, last_due = 0, last_out = 0, lat = 1;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          mon_en = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
  endtask

  // Monitor: one comparison of if_id_r per rising edge.
  initial forever begin
    logic [64:0] exp;
    @(posedge clk);
    edge_cnt++;
    #1;
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp = sbq[0].v;
        void'(sbq.pop_front());
      end else exp = BUBBLE;
      chk("if_id_r", if_id_r, exp);
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0;
    pend.delete(); sbq.delete(); epoch++; exp_pc = RESET_PC; last_due = 0;
    #1;
    chk("reset_bubble", if_id_r, BUBBLE);
    chk("reset_addr", imem_req_addr, RESET_PC);
    mon_en = 1;
    repeat (n) @(negedge clk);
    reset_n = 1;
    last_out = edge_cnt;
  endtask

  // One clock of stimulus. mode: 0 no redirect, 1 redirect, 2 redirect only when a
  // response and a buffered word coincide, 3 random redirect.
  task automatic cycle(input int mode, input logic [31:0] tgt, input bit rdy, input bit hold,
                       output bit did);
    int    c, stale, d, e;
    bit    rsp, redir, exp_v;
    mreq_t h, m;
    @(negedge clk);
    c   = edge_cnt + 1;
    rsp = (pend.size() > 0) && (pend[0].due <= c) && !hold;
    case (mode)
      1:       redir = 1;
      2:       redir = rsp && (sbq.size() > 0);
      3:       redir = ($urandom_range(0, 29) == 0);
      default: redir = 0;
    endcase
    did = redir;
    redirect_valid = redir; redirect_pc = tgt; imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? inst_of(pend[0].addr) : 32'hdead_beef;
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    exp_v = !redir && (stale == 0) && (pend.size() + sbq.size() < DEPTH);
    #2;
    chk("req_valid", imem_req_valid, exp_v);
    if (imem_req_valid && rdy) begin
      chk("req_addr", imem_req_addr, exp_pc);
      d = (c + lat > last_due + 1) ? c + lat : last_due + 1;
      last_due = d;
      m.addr = imem_req_addr; m.ep = epoch; m.due = d;
      pend.push_back(m);
      exp_pc = exp_pc + 32'd4;
    end
    if (rsp) begin
      h = pend.pop_front();
      if (h.ep == epoch && !redir) begin
        e = (c + 1 > last_out + 1) ? c + 1 : last_out + 1;
        last_out = e;
        sbq.push_back('{v: {h.addr, inst_of(h.addr), 1'b0}, e: e});
      end
    end
    if (redir) begin
      epoch++;
      sbq.delete();
      exp_pc = {tgt[31:2], 2'b00};
      last_out = c;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    bit did;
    repeat (n) cycle(0, 32'h0, rdy, 0, did);
  endtask

  initial begin
    bit did;
    int k;
    do_reset(3);
    lat = 1; run(20, 1);
    lat = 3; run(20, 1);

    k = 0;
    while (pend.size() != 2 && k < 20) begin cycle(0, 0, 1, 0, did); k++; end
    cycle(1, 32'h0000_0202, 1, 0, did);
    run(15, 1);

    lat = 1; run(6, 1);
    did = 0; k = 0;
    while (!did && k < 30) begin cycle(2, 32'h0000_0040, 1, 0, did); k++; end
    run(10, 1);

    lat = 3; run(4, 1);
    cycle(1, 32'h0000_0100, 1, 0, did);
    cycle(1, 32'h0000_0300, 1, 0, did);
    run(15, 1);

    lat = 2; run(5, 0);
    cycle(1, 32'hFFFF_FFF4, 1, 0, did);
    run(12, 1);
    do_reset(2);
    run(10, 1);

    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 4);
      cycle(3, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, did);
      if (i % 500 == 499) do_reset($urandom_range(1, 3));
    end

    run(30, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
